zbt_segment_ring_ctrl: RTL and testbench
========================================

Name: zbt_segment_ring_ctrl

Overview:
Parametrised successor to the Ethernet/ZBT stream glue. It arbitrates one ZBT port between a burst writer (Ethernet receiver) and a sequential reader (bitstream buffer), and tracks the fill level of a ring of 2^SEG_BITS equal segments. It grants write bursts only while a free segment exists, stalls the reader while the ring is empty or a write owns the port, and reports prefill completion, fill level and sticky overflow/underflow. It sits between the Ethernet unit, the ZBT bitstream reader and the system parser.

Parameters:
ADDR_WIDTH, 19, ZBT word address width.
DATA_WIDTH, 32, ZBT data width.
SEG_BITS, 1, log2 of segment count; NUM_SEGS = 2^SEG_BITS; segment = top SEG_BITS address bits.
INIT_CYCLES, 1048575, power-up delay in cycles before the first write grant.
PREFILL_SEGS, 1, full segments required before the reader is released; range 1..NUM_SEGS.

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
Flush_I  in  1  synchronous clear of fill state (stream restart)
Wr_Active_I  in  1  writer is mid-burst
Wr_Ready_O  out  1  burst grant to writer
Wr_En_I  in  1  writer word strobe
Wr_Address_I  in  ADDR_WIDTH  writer word address
Wr_Data_I  in  DATA_WIDTH  writer data
Rd_Address_I  in  ADDR_WIDTH  reader word address
Rd_Busy_O  out  1  reader must not consume this cycle
ZBT_Address_O  out  ADDR_WIDTH  ZBT address
ZBT_Data_O  out  DATA_WIDTH  ZBT write data
ZBT_Write_En_O  out  1  ZBT write enable
Initial_Fill_O  out  1  sticky: prefill reached
Fill_Level_O  out  SEG_BITS+1  full segments held
Overflow_O  out  1  sticky: segment completed while ring full
Underflow_O  out  1  sticky: reader left a segment while ring empty

Behaviour:
- Reset values: Wr_Ready_O=0, Initial_Fill_O=0, Fill_Level_O=0, Overflow_O=0, Underflow_O=0, init counter=0, rd_seg_dly=0. Rd_Busy_O=1 after reset.
- Port mux, combinational, 0 latency: ZBT_Write_En_O=Wr_En_I, ZBT_Data_O=Wr_Data_I, ZBT_Address_O = Wr_En_I ? Wr_Address_I : Rd_Address_I. The writer always wins.
- Init counter increments from 0 and saturates at INIT_CYCLES. init_done = (count==INIT_CYCLES). Flush_I does not restart it.
- seg_done (write completion) = Wr_En_I & low (ADDR_WIDTH-SEG_BITS) bits of Wr_Address_I all ones.
- rd_seg_dly registers the top SEG_BITS of Rd_Address_I every cycle. seg_freed (read completion) = current rd segment != rd_seg_dly.
- Fill level update, registered:
  - seg_done only: +1. If already NUM_SEGS, hold the count and set Overflow_O.
  - seg_freed only: -1. If already 0, hold at 0 and set Underflow_O.
  - both in the same cycle: net 0, no flags.
- Flush_I (highest priority after reset): Fill_Level_O=0, Initial_Fill_O=0, Overflow_O=0, Underflow_O=0, Wr_Ready_O=0. rd_seg_dly loads the current rd segment so no spurious seg_freed follows.
- Initial_Fill_O goes to 1 on the cycle after Fill_Level reaches PREFILL_SEGS. It stays 1 until reset or Flush_I.
- Wr_Ready_O, registered, priority order:
  - Wr_Active_I -> 0
  - else init_done & (next fill level < NUM_SEGS) -> 1
  - else 0
  The grant therefore drops one cycle after the writer starts; an idle writer with a full ring sees 0.
- Rd_Busy_O = Wr_En_I | ~Initial_Fill_O | (Fill_Level_O==0), combinational.
- Reset mid-burst: all state clears immediately. The writer must abort, since Wr_Ready_O=0.
- No data storage in the block; the reader guarantees it never crosses into the write segment, and Underflow_O flags a violation.

Test Plan:
(Bench uses ADDR_WIDTH=8, SEG_BITS=2, INIT_CYCLES=16, PREFILL_SEGS=2; segment = 64 words.)
- Reset release, Wr_Active_I=0 -> Wr_Ready_O=0 for cycles 1..16, then 1 from cycle 17 or 18; Rd_Busy_O=1 throughout.
- Writer bursts addresses 0x00..0x3F, then 0x40..0x7F -> Fill_Level_O goes 1, then 2; Initial_Fill_O=1 the cycle after the 0x7F write; Rd_Busy_O falls to 0 when Wr_En_I=0.
- Fill to 4 segments, writer idle -> Wr_Ready_O=0. Write 0x3F again -> Overflow_O=1, Fill_Level_O stays 4.
- Same cycle: Wr_En_I at 0xBF and Rd_Address_I moves 0x3F->0x40 -> Fill_Level_O unchanged, no flags.
- With Wr_En_I=1 at 0x10 and Rd_Address_I=0x55 -> ZBT_Address_O=0x10, Rd_Busy_O=1. Drop Wr_En_I -> ZBT_Address_O=0x55.
- Flush_I pulse with fill=3 and Overflow_O=1 -> next cycle all status outputs 0. A reader at segment 2 afterwards produces no Underflow_O. Async reset mid-burst -> all outputs to reset values without a clock edge.

Source files
------------

// File: rtl/zbt_segment_ring_ctrl.sv
// ZBT port arbiter and segment ring fill tracker.
// A burst writer and a sequential reader share one ZBT port. The writer always
// wins the port. The ZBT buffer is treated as a ring of equal segments; the
// block counts how many segments hold unread data and gates the writer grant
// and the reader stall from that count.
module zbt_segment_ring_ctrl #(
    parameter int ADDR_WIDTH   = 19,
    parameter int DATA_WIDTH   = 32,
    parameter int SEG_BITS     = 1,
    parameter int INIT_CYCLES  = 1048575,
    parameter int PREFILL_SEGS = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  Flush_I,
    input  logic                  Wr_Active_I,
    output logic                  Wr_Ready_O,
    input  logic                  Wr_En_I,
    input  logic [ADDR_WIDTH-1:0] Wr_Address_I,
    input  logic [DATA_WIDTH-1:0] Wr_Data_I,
    input  logic [ADDR_WIDTH-1:0] Rd_Address_I,
    output logic                  Rd_Busy_O,
    output logic [ADDR_WIDTH-1:0] ZBT_Address_O,
    output logic [DATA_WIDTH-1:0] ZBT_Data_O,
    output logic                  ZBT_Write_En_O,
    output logic                  Initial_Fill_O,
    output logic [SEG_BITS:0]     Fill_Level_O,
    output logic                  Overflow_O,
    output logic                  Underflow_O
);

    localparam int                LOW_BITS  = ADDR_WIDTH - SEG_BITS;
    localparam int                CNT_W     = $clog2(INIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYCLES);
    localparam logic [SEG_BITS:0] FULL      = (SEG_BITS + 1)'(1 << SEG_BITS);
    localparam logic [SEG_BITS:0] PREFILL   = (SEG_BITS + 1)'(PREFILL_SEGS);

    logic [CNT_W-1:0]    r_init_cnt;
    logic [SEG_BITS-1:0] r_rd_seg_dly;
    logic [SEG_BITS:0]   r_fill;
    logic                r_initial_fill;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_wr_ready;

    logic                w_init_done;
    logic                w_seg_done;
    logic [SEG_BITS-1:0] w_rd_seg;
    logic                w_seg_freed;
    logic [SEG_BITS:0]   w_fill_nxt;
    logic                w_ovf_set;
    logic                w_unf_set;

    // Port mux: the writer owns the port whenever it strobes a word.
    always_comb begin
        ZBT_Write_En_O = Wr_En_I;
        ZBT_Data_O     = Wr_Data_I;
        ZBT_Address_O  = Wr_En_I ? Wr_Address_I : Rd_Address_I;
    end

    assign w_init_done = (r_init_cnt == INIT_LAST);
    assign w_seg_done  = Wr_En_I & (&Wr_Address_I[LOW_BITS-1:0]);
    assign w_rd_seg    = Rd_Address_I[ADDR_WIDTH-1 -: SEG_BITS];
    assign w_seg_freed = (w_rd_seg != r_rd_seg_dly);

    // Next fill level; a write and a read completing together cancel out.
    always_comb begin
        w_fill_nxt = r_fill;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        if (w_seg_done && !w_seg_freed) begin
            if (r_fill == FULL) w_ovf_set = 1'b1;
            else                w_fill_nxt = r_fill + 1'b1;
        end else if (w_seg_freed && !w_seg_done) begin
            if (r_fill == '0) w_unf_set = 1'b1;
            else              w_fill_nxt = r_fill - 1'b1;
        end
    end

    // Power-up delay counter; saturates and is not affected by a flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                    r_init_cnt <= '0;
        else if (r_init_cnt != INIT_LAST) r_init_cnt <= r_init_cnt + 1'b1;
    end

    // Reader segment history; tracking it on flush too avoids a spurious free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_rd_seg_dly <= '0;
        else       r_rd_seg_dly <= w_rd_seg;
    end

    // Fill level, sticky status flags and writer grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fill         <= '0;
            r_initial_fill <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_wr_ready     <= 1'b0;
        end else if (Flush_I) begin
            r_fill         <= '0;
            r_initial_fill <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_wr_ready     <= 1'b0;
        end else begin
            r_fill         <= w_fill_nxt;
            r_initial_fill <= r_initial_fill | (r_fill >= PREFILL);
            r_overflow     <= r_overflow | w_ovf_set;
            r_underflow    <= r_underflow | w_unf_set;
            if (Wr_Active_I)                          r_wr_ready <= 1'b0;
            else if (w_init_done && (w_fill_nxt < FULL)) r_wr_ready <= 1'b1;
            else                                      r_wr_ready <= 1'b0;
        end
    end

    assign Wr_Ready_O     = r_wr_ready;
    assign Initial_Fill_O = r_initial_fill;
    assign Fill_Level_O   = r_fill;
    assign Overflow_O     = r_overflow;
    assign Underflow_O    = r_underflow;
    assign Rd_Busy_O      = Wr_En_I | ~r_initial_fill | (r_fill == '0);

endmodule

// File: tb/tb_zbt_segment_ring_ctrl.sv
// Directed bench: 8-bit addresses, 4 segments of 64 words, 16 init cycles,
// prefill of 2 segments.
module tb_zbt_segment_ring_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SB = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          Flush_I;
    logic          Wr_Active_I;
    logic          Wr_Ready_O;
    logic          Wr_En_I;
    logic [AW-1:0] Wr_Address_I;
    logic [DW-1:0] Wr_Data_I;
    logic [AW-1:0] Rd_Address_I;
    logic          Rd_Busy_O;
    logic [AW-1:0] ZBT_Address_O;
    logic [DW-1:0] ZBT_Data_O;
    logic          ZBT_Write_En_O;
    logic          Initial_Fill_O;
    logic [SB:0]   Fill_Level_O;
    logic          Overflow_O;
    logic          Underflow_O;

    int n_checks = 0;
    int n_pass   = 0;

    zbt_segment_ring_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SEG_BITS    (SB),
        .INIT_CYCLES (16),
        .PREFILL_SEGS(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .Flush_I       (Flush_I),
        .Wr_Active_I   (Wr_Active_I),
        .Wr_Ready_O    (Wr_Ready_O),
        .Wr_En_I       (Wr_En_I),
        .Wr_Address_I  (Wr_Address_I),
        .Wr_Data_I     (Wr_Data_I),
        .Rd_Address_I  (Rd_Address_I),
        .Rd_Busy_O     (Rd_Busy_O),
        .ZBT_Address_O (ZBT_Address_O),
        .ZBT_Data_O    (ZBT_Data_O),
        .ZBT_Write_En_O(ZBT_Write_En_O),
        .Initial_Fill_O(Initial_Fill_O),
        .Fill_Level_O  (Fill_Level_O),
        .Overflow_O    (Overflow_O),
        .Underflow_O   (Underflow_O)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic burst(input logic [AW-1:0] base);
        for (int i = 0; i < 64; i++) begin
            Wr_En_I      = 1'b1;
            Wr_Address_I = base + AW'(i);
            Wr_Data_I    = 32'hA500_0000 | 32'(base + AW'(i));
            tick();
        end
    endtask

    initial begin
        reset        = 1'b1;
        Flush_I      = 1'b0;
        Wr_Active_I  = 1'b0;
        Wr_En_I      = 1'b0;
        Wr_Address_I = '0;
        Wr_Data_I    = '0;
        Rd_Address_I = '0;
        #12;
        check("rst_ready", 32'(Wr_Ready_O), 0);
        check("rst_fill",  32'(Fill_Level_O), 0);
        check("rst_init",  32'(Initial_Fill_O), 0);
        check("rst_ovf",   32'(Overflow_O), 0);
        check("rst_unf",   32'(Underflow_O), 0);
        check("rst_busy",  32'(Rd_Busy_O), 1);
        reset = 1'b0;

        // Power-up delay: no grant for 16 edges, grant on the 17th
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("init_ready", 32'(Wr_Ready_O), 0);
            check("init_busy",  32'(Rd_Busy_O), 1);
        end
        tick();
        check("init_done_ready", 32'(Wr_Ready_O), 1);

        // Writer starts: grant is registered, drops one edge later
        Wr_Active_I = 1'b1;
        #1;
        check("grant_before_edge", 32'(Wr_Ready_O), 1);
        burst(8'h00);
        check("fill_after_seg0", 32'(Fill_Level_O), 1);
        check("ready_mid_burst", 32'(Wr_Ready_O), 0);
        check("zbt_we",   32'(ZBT_Write_En_O), 1);
        check("zbt_data", ZBT_Data_O, 32'hA500_003F);
        check("zbt_addr_wr", 32'(ZBT_Address_O), 32'h3F);
        check("busy_wr", 32'(Rd_Busy_O), 1);
        burst(8'h40);
        check("fill_after_seg1", 32'(Fill_Level_O), 2);
        check("initfill_not_yet", 32'(Initial_Fill_O), 0);
        Wr_En_I     = 1'b0;
        Wr_Active_I = 1'b0;
        tick();
        check("initfill_set", 32'(Initial_Fill_O), 1);
        check("busy_released", 32'(Rd_Busy_O), 0);
        check("fill2_idle_ready", 32'(Wr_Ready_O), 1);

        // Third segment, then simultaneous write/read completion
        Wr_Active_I = 1'b1;
        burst(8'h80);
        check("fill_after_seg2", 32'(Fill_Level_O), 3);
        Wr_En_I      = 1'b0;
        Wr_Active_I  = 1'b0;
        Rd_Address_I = 8'h3F;
        tick();
        check("rd_in_seg_fill", 32'(Fill_Level_O), 3);
        Wr_En_I      = 1'b1;
        Wr_Address_I = 8'hBF;
        Rd_Address_I = 8'h40;
        tick();
        Wr_En_I = 1'b0;
        check("both_fill", 32'(Fill_Level_O), 3);
        check("both_ovf",  32'(Overflow_O), 0);
        check("both_unf",  32'(Underflow_O), 0);

        // Fill the ring, then overflow
        Wr_Active_I = 1'b1;
        burst(8'hC0);
        check("fill_full", 32'(Fill_Level_O), 4);
        Wr_En_I     = 1'b0;
        Wr_Active_I = 1'b0;
        tick();
        check("full_idle_ready", 32'(Wr_Ready_O), 0);
        check("full_no_ovf", 32'(Overflow_O), 0);
        Wr_En_I      = 1'b1;
        Wr_Address_I = 8'h3F;
        tick();
        Wr_En_I = 1'b0;
        check("ovf_set",  32'(Overflow_O), 1);
        check("ovf_fill", 32'(Fill_Level_O), 4);

        // Port mux priority
        Wr_En_I      = 1'b1;
        Wr_Address_I = 8'h10;
        Rd_Address_I = 8'h55;
        #1;
        check("mux_wr_addr", 32'(ZBT_Address_O), 32'h10);
        check("mux_wr_busy", 32'(Rd_Busy_O), 1);
        Wr_En_I = 1'b0;
        #1;
        check("mux_rd_addr", 32'(ZBT_Address_O), 32'h55);
        check("mux_rd_busy", 32'(Rd_Busy_O), 0);
        check("mux_rd_we",   32'(ZBT_Write_En_O), 0);

        // Reader frees a segment, then flush
        Rd_Address_I = 8'h80;
        tick();
        check("freed_fill", 32'(Fill_Level_O), 3);
        check("freed_unf",  32'(Underflow_O), 0);
        Flush_I = 1'b1;
        tick();
        Flush_I = 1'b0;
        check("flush_fill",  32'(Fill_Level_O), 0);
        check("flush_init",  32'(Initial_Fill_O), 0);
        check("flush_ovf",   32'(Overflow_O), 0);
        check("flush_unf",   32'(Underflow_O), 0);
        check("flush_ready", 32'(Wr_Ready_O), 0);
        check("flush_busy",  32'(Rd_Busy_O), 1);
        tick();
        tick();
        check("post_flush_unf",   32'(Underflow_O), 0);
        check("post_flush_fill",  32'(Fill_Level_O), 0);
        check("post_flush_ready", 32'(Wr_Ready_O), 1);

        // Reader leaves a segment of an empty ring
        Rd_Address_I = 8'hC0;
        tick();
        check("unf_set",  32'(Underflow_O), 1);
        check("unf_fill", 32'(Fill_Level_O), 0);

        // Asynchronous reset mid-burst
        Wr_Active_I  = 1'b1;
        Wr_En_I      = 1'b1;
        Wr_Address_I = 8'h3F;
        tick();
        check("pre_rst_fill", 32'(Fill_Level_O), 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_fill",  32'(Fill_Level_O), 0);
        check("arst_unf",   32'(Underflow_O), 0);
        check("arst_ready", 32'(Wr_Ready_O), 0);
        check("arst_busy",  32'(Rd_Busy_O), 1);
        Wr_En_I     = 1'b0;
        Wr_Active_I = 1'b0;
        #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("arst_init_restart", 32'(Wr_Ready_O), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
